fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised instruction-fetch and timing sequencer for the 6502 core; successor to the fixed 16-bit IDLE/FETCH/DECODE/EXECUTE control unit. It loads the PC from the reset vector, then fetches the opcode plus 0–2 operand bytes per instruction over a ready-qualified memory read port. It presents each complete instruction to the execute stage through a valid/ready handshake and accepts PC redirects for branches, jumps and interrupts. It sits between the bus interface and the decode/execute logic, and an external combinational length decoder tells it how many operand bytes to fetch.

## Interface
- ADDR_W, 16, address/PC width.
- DATA_W, 8, memory data and opcode width.
- RESET_VECTOR, 16'hFFFC, address of the vector low byte; the high byte is at RESET_VECTOR+1, mod 2^ADDR_W.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- mem_rd  out  1  read request.
- mem_addr  out  ADDR_W  read address, stable while mem_rd is high and not yet accepted.
- mem_ready  in  1  a byte transfers in any cycle where mem_rd && mem_ready.
- mem_rdata  in  DATA_W  read data, valid in the transfer cycle.
- sync  out  1  high while the opcode byte is being requested (6502 SYNC).
- opcode  out  DATA_W  registered opcode of the current instruction.
- op_len  in  2  operand byte count for `opcode`: 0, 1 or 2; 3 is illegal.
- instr_valid  out  1  complete instruction presented.
- instr_ready  in  1  execute stage accepts the instruction.
- operand  out  2*DATA_W  byte0 in [DATA_W-1:0], byte1 in the upper half; bytes not fetched read as zero.
- instr_len  out  2  operand count actually fetched.
- instr_pc  out  ADDR_W  address of the opcode byte.
- len_err  out  1  one-cycle pulse when op_len==3 is sampled.
- redirect  in  1  load a new PC (single-cycle pulse).
- redirect_pc  in  ADDR_W  target address.

## Operation
- States:
  - RST: transitions to VEC_LO unconditionally on the first edge after reset is released.
  - VEC_LO: requests RESET_VECTOR; on transfer, captures pc[7:0] and goes to VEC_HI.
  - VEC_HI: requests RESET_VECTOR+1; on transfer, captures pc[15:8] and goes to FETCH_OP.
  - FETCH_OP: requests pc; on transfer, captures opcode, sets instr_pc=pc, pc=pc+1, and goes to DECODE.
  - DECODE: no request. Samples op_len: 0 goes to ISSUE, 1 or 2 goes to OPND1, 3 pulses len_err and goes to ISSUE with instr_len=0.
  - OPND1: requests pc; on transfer, captures operand byte0, sets pc=pc+1, and goes to OPND2 if the latched len is 2, else to ISSUE.
  - OPND2: requests pc; on transfer, captures byte1, sets pc=pc+1, and goes to ISSUE.
  - ISSUE: instr_valid=1. On instr_ready, goes to FETCH_OP; otherwise holds all outputs.
- For ADDR_W>16 the vector fills pc[15:0] and clears the upper bits. For ADDR_W<16 the vector high byte is truncated.
- mem_rd=1 in VEC_LO, VEC_HI, FETCH_OP, OPND1 and OPND2, else 0.
- mem_addr=RESET_VECTOR in VEC_LO, RESET_VECTOR+1 in VEC_HI, and pc otherwise.
- sync=1 only in FETCH_OP.
- When mem_ready is low the state, mem_addr and mem_rd hold (wait states, unlimited).
- All PC arithmetic is modulo 2^ADDR_W, so 0xFFFF+1 wraps to 0x0000.
- Redirect:
  - Honoured in FETCH_OP, DECODE, OPND1, OPND2 and ISSUE; ignored in RST, VEC_LO and VEC_HI.
  - Takes effect next cycle: pc=redirect_pc, state FETCH_OP, partial operands discarded, instr_valid drops.
  - It overrides a same-cycle memory transfer, whose data is discarded.
  - With a same-cycle instr_valid && instr_ready, the handshake counts as completed (the instruction is consumed) and the redirect still applies.
- Reset asserted at any time clears to RST immediately (asynchronous); an in-flight request is abandoned.

## Timing
- Reset values:
  - state RST, pc=RESET_VECTOR.
  - mem_rd=0, mem_addr=RESET_VECTOR, sync=0.
  - opcode=0, operand=0, instr_len=0, instr_pc=0.
  - instr_valid=0, len_err=0.
- With mem_ready tied high:
  - First mem_rd occurs in the 2nd cycle after reset is released.
  - The first opcode request occurs in the 4th cycle.
- From the FETCH_OP transfer at cycle t, instr_valid is first high at:
  - t+2 for len 0;
  - t+3 for len 1;
  - t+4 for len 2.
  Each wait-state cycle adds one.
- Back-to-back throughput with instr_ready high: 3/4/5 cycles per 0/1/2-operand instruction.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Vector load: mem[FFFC]=00, mem[FFFD]=80, reset pulse -> reads FFFC, then FFFD, then sync with mem_addr=8000, in cycles 2/3/4 after release.
- Lengths: 8000: EA(len0); A9 42(len1); 4C 34 12(len2), instr_ready=1 ->
  - instr_pc 8000/8001/8003;
  - operand 0000/0042/1234;
  - instr_len 0/1/2;
  - valid spacing 3/4/5 cycles.
- Backpressure and wait states: instr_ready low for 4 cycles, then mem_ready low for 2 cycles during OPND1 -> all outputs held, no extra reads, mem_addr stable; the instruction is delivered once.
- Redirect: redirect_pc=C000 pulsed in OPND1 of 4C at 8003 -> next cycle FETCH_OP at C000, no instr_valid for 4C; then redirect in VEC_HI -> ignored.
- Wrap and illegal length: opcode at FFFF, op_len=2 -> operands from 0000 and 0001, next fetch 0002; op_len=3 -> one-cycle len_err, instr_len=0, next fetch at instr_pc+1.
- Reset mid-fetch: reset asserted in OPND2 -> outputs take reset values in the same cycle, and the vector fetch restarts after release.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory read port and instruction issue port of the fetch sequencer
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                sync;
    logic [DATA_W-1:0]   opcode;
    logic [1:0]          op_len;
    logic                instr_valid;
    logic                instr_ready;
    logic [2*DATA_W-1:0] operand;
    logic [1:0]          instr_len;
    logic [ADDR_W-1:0]   instr_pc;
    logic                len_err;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;

    modport master (
        output mem_rd, mem_addr, sync, opcode, instr_valid, operand, instr_len, instr_pc, len_err,
        input  mem_ready, mem_rdata, op_len, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_rd, mem_addr, sync, opcode, instr_valid, operand, instr_len, instr_pc, len_err,
        output mem_ready, mem_rdata, op_len, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - reset-vector load, opcode/operand fetch and instruction issue sequencer
module fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(16'hFFFC)
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] VEC_HI_ADDR = RESET_VECTOR + ADDR_W'(1);

    typedef enum logic [2:0] {
        S_RST, S_VEC_LO, S_VEC_HI, S_FETCH_OP, S_DECODE, S_OPND1, S_OPND2, S_ISSUE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic              xfer;
    logic              take_redirect;

    assign xfer          = bus.mem_rd && bus.mem_ready;
    assign take_redirect = bus.redirect &&
                           (state inside {S_FETCH_OP, S_DECODE, S_OPND1, S_OPND2, S_ISSUE});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RST;
        else       state <= state_next;
    end

    // Outputs depend on state and registers only; inputs steer next state alone.
    always_comb begin
        state_next      = state;
        bus.mem_rd      = 1'b0;
        bus.mem_addr    = pc;
        bus.sync        = 1'b0;
        bus.instr_valid = 1'b0;
        case (state)
            S_RST:    state_next = S_VEC_LO;
            S_VEC_LO: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = RESET_VECTOR;
                if (bus.mem_ready) state_next = S_VEC_HI;
            end
            S_VEC_HI: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = VEC_HI_ADDR;
                if (bus.mem_ready) state_next = S_FETCH_OP;
            end
            S_FETCH_OP: begin
                bus.mem_rd = 1'b1;
                bus.sync   = 1'b1;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (bus.op_len == 2'd1 || bus.op_len == 2'd2) state_next = S_OPND1;
                else                                          state_next = S_ISSUE;
            end
            S_OPND1: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) state_next = (bus.instr_len == 2'd2) ? S_OPND2 : S_ISSUE;
            end
            S_OPND2: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) state_next = S_FETCH_OP;
            end
            default: state_next = S_RST;
        endcase
        if (take_redirect) state_next = S_FETCH_OP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_VECTOR;
            bus.opcode    <= '0;
            bus.operand   <= '0;
            bus.instr_len <= 2'd0;
            bus.instr_pc  <= '0;
            bus.len_err   <= 1'b0;
        end else begin
            bus.len_err <= 1'b0;
            if (take_redirect) begin
                // A redirect wins over any same-cycle transfer; that byte is dropped.
                pc <= bus.redirect_pc;
            end else begin
                case (state)
                    S_VEC_LO: if (xfer) pc <= ADDR_W'(bus.mem_rdata[7:0]);
                    S_VEC_HI: if (xfer) pc <= ADDR_W'({bus.mem_rdata[7:0], pc[7:0]});
                    S_FETCH_OP: if (xfer) begin
                        bus.opcode    <= bus.mem_rdata;
                        bus.instr_pc  <= pc;
                        bus.operand   <= '0;
                        bus.instr_len <= 2'd0;
                        pc            <= pc + ADDR_W'(1);
                    end
                    S_DECODE: begin
                        bus.instr_len <= (bus.op_len == 2'd3) ? 2'd0 : bus.op_len;
                        bus.len_err   <= (bus.op_len == 2'd3);
                    end
                    S_OPND1: if (xfer) begin
                        bus.operand[DATA_W-1:0] <= bus.mem_rdata;
                        pc                      <= pc + ADDR_W'(1);
                    end
                    S_OPND2: if (xfer) begin
                        bus.operand[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
                        pc                             <= pc + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed, table-driven bench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus();
    fetch_sequencer #(.ADDR_W(16), .DATA_W(8), .RESET_VECTOR(16'hFFFC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [7:0] mem [0:65535];

    function automatic logic [1:0] len_of(input logic [7:0] o);
        case (o)
            8'hA9:   return 2'd1;
            8'h4C:   return 2'd2;
            8'h02:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.op_len    = len_of(bus.opcode);

    typedef struct { int cyc; logic [15:0] addr; logic sync; } rd_t;
    typedef struct { int cyc; logic [15:0] pc; logic [7:0] opc; logic [15:0] opnd; logic [1:0] len; } acc_t;
    typedef struct { logic [15:0] pc; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;
                     logic [15:0] opnd; logic [1:0] len; int cyc; } vec_t;

    rd_t  rd_log[$];
    acc_t acc_log[$];
    vec_t tbl[4];
    int   cur;
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cur);
        end
    endtask

    // Sample on the falling edge, then advance to 1 time unit after the next rising edge.
    task automatic step();
        rd_t  r;
        acc_t a;
        @(negedge clk);
        if (!reset) begin
            if (bus.mem_rd && bus.mem_ready) begin
                r.cyc = cur; r.addr = bus.mem_addr; r.sync = bus.sync;
                rd_log.push_back(r);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                a.cyc = cur; a.pc = bus.instr_pc; a.opc = bus.opcode;
                a.opnd = bus.operand; a.len = bus.instr_len;
                acc_log.push_back(a);
            end
        end
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic goto(input int k);
        while (cur < k) step();
    endtask

    task automatic start_phase();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_log.delete();
        acc_log.delete();
        reset = 1'b0;
        cur = 1;
    endtask

    task automatic fill_mem(input logic [7:0] lo, input logic [7:0] hi);
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = lo;
        mem[16'hFFFD] = hi;
    endtask

    task automatic load_table();
        fill_mem(8'h00, 8'h80);
        for (int i = 0; i < 4; i++) begin
            mem[tbl[i].pc] = tbl[i].b0;
            if (tbl[i].len >= 2'd1) mem[tbl[i].pc + 16'd1] = tbl[i].b1;
            if (tbl[i].len == 2'd2) mem[tbl[i].pc + 16'd2] = tbl[i].b2;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_rd"},      bus.mem_rd, 0);
        check({tag, "_mem_addr"},    bus.mem_addr, 16'hFFFC);
        check({tag, "_sync"},        bus.sync, 0);
        check({tag, "_opcode"},      bus.opcode, 0);
        check({tag, "_operand"},     bus.operand, 0);
        check({tag, "_instr_len"},   bus.instr_len, 0);
        check({tag, "_instr_pc"},    bus.instr_pc, 0);
        check({tag, "_instr_valid"}, bus.instr_valid, 0);
        check({tag, "_len_err"},     bus.len_err, 0);
    endtask

    task automatic check_vec(input string tag, input logic [15:0] target);
        if (rd_log.size() < 3) begin
            check({tag, "_vec_reads"}, rd_log.size(), 3);
        end else begin
            check({tag, "_vlo_cyc"},  rd_log[0].cyc, 2);
            check({tag, "_vlo_addr"}, rd_log[0].addr, 16'hFFFC);
            check({tag, "_vhi_cyc"},  rd_log[1].cyc, 3);
            check({tag, "_vhi_addr"}, rd_log[1].addr, 16'hFFFD);
            check({tag, "_op_cyc"},   rd_log[2].cyc, 4);
            check({tag, "_op_addr"},  rd_log[2].addr, target);
            check({tag, "_op_sync"},  rd_log[2].sync, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0;
        failures = 0;
        cur = 0;
        bus.mem_ready = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;

        tbl[0] = '{16'h8000, 8'hEA, 8'h00, 8'h00, 16'h0000, 2'd0, 6};
        tbl[1] = '{16'h8001, 8'hA9, 8'h42, 8'h00, 16'h0042, 2'd1, 10};
        tbl[2] = '{16'h8003, 8'h4C, 8'h34, 8'h12, 16'h1234, 2'd2, 15};
        tbl[3] = '{16'h8006, 8'hEA, 8'h00, 8'h00, 16'h0000, 2'd0, 18};

        load_table();
        @(posedge clk); #1;
        check_reset_vals("rst");

        // Lengths and back-to-back throughput.
        start_phase();
        goto(20);
        check_vec("a", 16'h8000);
        check("a_accept_count", acc_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_log.size()) begin
                check($sformatf("a%0d_pc", i),      acc_log[i].pc,   tbl[i].pc);
                check($sformatf("a%0d_opcode", i),  acc_log[i].opc,  tbl[i].b0);
                check($sformatf("a%0d_operand", i), acc_log[i].opnd, tbl[i].opnd);
                check($sformatf("a%0d_len", i),     acc_log[i].len,  tbl[i].len);
                check($sformatf("a%0d_cycle", i),   acc_log[i].cyc,  tbl[i].cyc);
            end
        end

        // Backpressure then wait states in OPND1.
        fill_mem(8'h00, 8'h80);
        mem[16'h8001] = 8'hA9;
        mem[16'h8002] = 8'h77;
        start_phase();
        bus.instr_ready = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            goto(c);
            check("b_hold_valid", bus.instr_valid, 1);
            check("b_hold_pc",    bus.instr_pc, 16'h8000);
            check("b_hold_op",    bus.opcode, 8'hEA);
            check("b_hold_no_rd", bus.mem_rd, 0);
        end
        goto(10);
        bus.instr_ready = 1'b1;
        goto(13);
        bus.mem_ready = 1'b0;
        check("b_ws1_rd",   bus.mem_rd, 1);
        check("b_ws1_addr", bus.mem_addr, 16'h8002);
        goto(14);
        check("b_ws2_rd",   bus.mem_rd, 1);
        check("b_ws2_addr", bus.mem_addr, 16'h8002);
        goto(15);
        bus.mem_ready = 1'b1;
        check("b_ws3_addr", bus.mem_addr, 16'h8002);
        goto(16);
        check("b_a9_valid",   bus.instr_valid, 1);
        check("b_a9_operand", bus.operand, 16'h0077);
        check("b_a9_len",     bus.instr_len, 1);
        goto(20);
        n = 0;
        foreach (acc_log[i]) if (acc_log[i].pc == 16'h8000) n++;
        check("b_once", n, 1);
        if (acc_log.size() > 0) check("b_ea_cycle", acc_log[0].cyc, 10);
        else check("b_ea_accepted", 0, 1);
        n = 0;
        foreach (rd_log[i]) if (rd_log[i].cyc < 11) n++;
        check("b_no_extra_reads", n, 3);
        n = 0;
        foreach (rd_log[i]) if (rd_log[i].addr == 16'h8002) n++;
        check("b_opnd_reads", n, 1);

        // Redirect ignored in VEC_HI, honoured in OPND1.
        load_table();
        start_phase();
        goto(3);
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hC000;
        goto(4);
        bus.redirect = 1'b0;
        check("c_vec_sync", bus.sync, 1);
        check("c_vec_addr", bus.mem_addr, 16'h8000);
        goto(13);
        check("c_opnd1_addr", bus.mem_addr, 16'h8004);
        bus.redirect = 1'b1;
        goto(14);
        bus.redirect = 1'b0;
        check("c_redir_sync",  bus.sync, 1);
        check("c_redir_addr",  bus.mem_addr, 16'hC000);
        check("c_redir_valid", bus.instr_valid, 0);
        goto(16);
        check("c_c000_valid", bus.instr_valid, 1);
        check("c_c000_pc",    bus.instr_pc, 16'hC000);
        goto(17);
        check("c_next_sync", bus.sync, 1);
        check("c_next_addr", bus.mem_addr, 16'hC001);
        goto(20);
        n = 0;
        foreach (acc_log[i]) if (acc_log[i].opc == 8'h4C) n++;
        check("c_no_4c", n, 0);
        check("c_accept_count", acc_log.size(), 4);

        // PC wrap with two operands, then an illegal length.
        fill_mem(8'hFF, 8'hFF);
        mem[16'hFFFF] = 8'h4C;
        mem[16'h0000] = 8'hCD;
        mem[16'h0001] = 8'hAB;
        mem[16'h0002] = 8'h02;
        start_phase();
        goto(9);
        check("d_fetch2_sync", bus.sync, 1);
        check("d_fetch2_addr", bus.mem_addr, 16'h0002);
        goto(10);
        check("d_decode_len_err", bus.len_err, 0);
        goto(11);
        check("d_len_err",   bus.len_err, 1);
        check("d_ill_valid", bus.instr_valid, 1);
        check("d_ill_len",   bus.instr_len, 0);
        goto(12);
        check("d_len_err_drop", bus.len_err, 0);
        check("d_fetch3_addr",  bus.mem_addr, 16'h0003);
        goto(14);
        check_vec("d", 16'hFFFF);
        if (rd_log.size() >= 5) begin
            check("d_opnd0_addr", rd_log[3].addr, 16'h0000);
            check("d_opnd1_addr", rd_log[4].addr, 16'h0001);
        end else check("d_opnd_reads", rd_log.size(), 5);
        if (acc_log.size() >= 2) begin
            check("d_wrap_pc",      acc_log[0].pc, 16'hFFFF);
            check("d_wrap_operand", acc_log[0].opnd, 16'hABCD);
            check("d_wrap_len",     acc_log[0].len, 2);
            check("d_wrap_cycle",   acc_log[0].cyc, 8);
            check("d_ill_pc",       acc_log[1].pc, 16'h0002);
            check("d_ill_operand",  acc_log[1].opnd, 16'h0000);
            check("d_ill_cycle",    acc_log[1].cyc, 11);
        end else check("d_accept_count", acc_log.size(), 2);

        // Asynchronous reset during OPND2, then vector fetch restarts.
        load_table();
        start_phase();
        goto(14);
        check("e_opnd2_addr", bus.mem_addr, 16'h8005);
        reset = 1'b1;
        #1;
        check_reset_vals("e");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_log.delete();
        acc_log.delete();
        reset = 1'b0;
        cur = 1;
        goto(6);
        check_vec("e", 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
